// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control sequencer for a small 8-bit accumulator machine.
//   It fetches an opcode byte (and an operand byte for two-byte ops),
//   then drives PC, MAR, memory and accumulator controls one state at a time.
//   Every memory wait state is bounded by WAIT_MAX cycles; an expired wait
//   raises a sticky bus_error and parks the sequencer in HALT.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_p    in   synchronous active-high reset
//   start      in   leave IDLE and begin fetching
//   mem_rdata  in   [7:0] memory read data
//   mem_ready  in   memory access complete (honoured only in wait states)
//   zero_flag  in   accumulator-zero flag, used by JZ
//   pc_inc / load_pc / pc_rd_en           out  program counter controls
//   jmp_addr   out  [7:0] PC load value (latched operand)
//   mar_load / addr_sel                   out  MAR load, source 0=PC 1=operand
//   mem_rd_en / mem_wr_en                 out  memory strobes
//   acc_load / alu_sub / acc_rd_en / out_load  out  datapath controls
//   opcode     out  [3:0] latched opcode nibble
//   halted / bus_error / illegal_op       out  status
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       start,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    input  logic       zero_flag,
    output logic       pc_inc,
    output logic       load_pc,
    output logic       pc_rd_en,
    output logic [7:0] jmp_addr,
    output logic       mar_load,
    output logic       addr_sel,
    output logic       mem_rd_en,
    output logic       mem_wr_en,
    output logic       acc_load,
    output logic       alu_sub,
    output logic       acc_rd_en,
    output logic       out_load,
    output logic [3:0] opcode,
    output logic       halted,
    output logic       bus_error,
    output logic       illegal_op
);

    // Wait counter only needs to reach WAIT_MAX-1: the cycle it sits there
    // without mem_ready is the last permitted wait cycle.
    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F_ADDR = 4'd1;
    localparam logic [3:0] S_F_WAIT = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_O_ADDR = 4'd4;
    localparam logic [3:0] S_O_WAIT = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_E_ADDR = 4'd7;
    localparam logic [3:0] S_E_WAIT = 4'd8;
    localparam logic [3:0] S_WB     = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [3:0]    state_q, state_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [7:0]    operand_q, operand_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_error_q, bus_error_d;

    // Next-state, latch updates and per-state control strobes.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        wait_cnt_d  = {CW{1'b0}};      // any state change out of a wait clears it
        bus_error_d = bus_error_q;
        pc_inc      = 1'b0;
        load_pc     = 1'b0;
        pc_rd_en    = 1'b0;
        mar_load    = 1'b0;
        addr_sel    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        acc_load    = 1'b0;
        alu_sub     = 1'b0;
        acc_rd_en   = 1'b0;
        out_load    = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_F_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_F_ADDR, S_O_ADDR: begin
                pc_rd_en = 1'b1;
                mar_load = 1'b1;
                state_d  = (state_q == S_F_ADDR) ? S_F_WAIT : S_O_WAIT;
            end
            S_F_WAIT, S_O_WAIT: begin
                mem_rd_en = 1'b1;
                if (mem_ready) begin
                    pc_inc = 1'b1;
                    if (state_q == S_F_WAIT) begin
                        opcode_d = mem_rdata[7:4];
                        state_d  = S_DECODE;
                    end else begin
                        operand_d = mem_rdata;
                        state_d   = ((opcode_q == OP_JMP) || (opcode_q == OP_JZ)) ? S_EXEC : S_E_ADDR;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DECODE: begin
                case (opcode_q)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_JZ: state_d = S_O_ADDR;
                    OP_OUT: state_d = S_EXEC;
                    OP_HLT: state_d = S_HALT;
                    OP_NOP: state_d = S_F_ADDR;
                    default: begin
                        // Undefined opcodes flag once and then behave as NOP.
                        illegal_op = 1'b1;
                        state_d    = S_F_ADDR;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_JMP: load_pc = 1'b1;
                    OP_JZ:  load_pc = zero_flag;
                    OP_OUT: begin
                        acc_rd_en = 1'b1;
                        out_load  = 1'b1;
                    end
                    default: load_pc = 1'b0;
                endcase
                state_d = S_F_ADDR;
            end
            S_E_ADDR: begin
                mar_load = 1'b1;
                addr_sel = 1'b1;
                state_d  = S_E_WAIT;
            end
            S_E_WAIT: begin
                if (opcode_q == OP_STA) begin
                    mem_wr_en = 1'b1;
                    acc_rd_en = 1'b1;
                end else begin
                    mem_rd_en = 1'b1;
                end
                if (mem_ready) begin
                    state_d = (opcode_q == OP_STA) ? S_F_ADDR : S_WB;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_error_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_WB: begin
                // LDA leaves alu_sub low; the datapath loads memory data directly.
                acc_load = 1'b1;
                alu_sub  = (opcode_q == OP_SUB);
                state_d  = S_F_ADDR;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q     <= S_IDLE;
            opcode_q    <= 4'h0;
            operand_q   <= 8'h00;
            wait_cnt_q  <= {CW{1'b0}};
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign opcode    = opcode_q;
    assign jmp_addr  = operand_q;
    assign halted    = (state_q == S_HALT);
    assign bus_error = bus_error_q;

endmodule
